// File: rtl/gfx_addr_arbiter.sv
// Round-robin arbiter sharing one pixel address calculator among NREQ drawing engines,
// with tag pipeline and drained configuration update. Define GFX_ADDR_ARB_PRIO_EN for fixed priority.
module gfx_addr_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 3,
  parameter int BN   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid_i,
  output logic [NREQ-1:0]    req_ready_o,
  input  logic [NREQ*16-1:0] req_x_i,
  input  logic [NREQ*16-1:0] req_y_i,
  input  logic [31:0]        cfg_base_i,
  input  logic [1:0]         cfg_depth_i,
  input  logic [15:0]        cfg_width_i,
  input  logic               cfg_upd_i,
  output logic               cfg_busy_o,
  output logic [15:0]        calc_x_o,
  output logic [15:0]        calc_y_o,
  output logic [31:0]        calc_base_o,
  output logic [1:0]         calc_depth_o,
  output logic [15:0]        calc_width_o,
  input  logic [31:0]        calc_address_i,
  input  logic [BN:0]        calc_mb_i,
  input  logic [BN:0]        calc_me_i,
  input  logic [BN:0]        calc_ce_i,
  output logic [NREQ-1:0]    rsp_valid_o,
  output logic [31:0]        rsp_address_o,
  output logic [BN:0]        rsp_mb_o,
  output logic [BN:0]        rsp_me_o,
  output logic [BN:0]        rsp_ce_o,
  output logic               idle_o
);

  localparam int         IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [1:0] BPP16 = 2'd1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_APPLY, S_SETTLE} state_t;

  state_t          r_state;
  logic            r_settle;
  logic            r_again;
  logic            r_busy;
  logic [LAT-1:0]  r_tag_vld;
  logic [IW-1:0]   r_tag_id [LAT];
  logic [NREQ-1:0] r_rsp_vld;
  logic [15:0]     r_x, r_y;
  logic [31:0]     r_base, r_pend_base;
  logic [1:0]      r_depth, r_pend_depth;
  logic [15:0]     r_width, r_pend_width;
  logic [BN:0]     r_mb_d, r_me_d, r_ce_d;
  logic [31:0]     r_rsp_addr;
  logic [BN:0]     r_rsp_mb, r_rsp_me, r_rsp_ce;
  logic            w_any;
  logic            w_fire;
  logic [IW-1:0]   w_win;

  function automatic logic [NREQ-1:0] f_onehot(input logic [IW-1:0] id);
    return {{(NREQ-1){1'b0}}, 1'b1} << id;
  endfunction

`ifdef GFX_ADDR_ARB_PRIO_EN
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        w_any = 1'b1;
        w_win = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] r_ptr;

  // Search starts at r_ptr, the requester after the last one granted.
  always_comb begin
    int v_idx;
    w_any = 1'b0;
    w_win = '0;
    v_idx = 0;
    for (int i = 0; i < NREQ; i++) begin
      v_idx = int'(r_ptr) + i;
      if (v_idx >= NREQ) v_idx = v_idx - NREQ;
      if (!w_any && req_valid_i[v_idx]) begin
        w_any = 1'b1;
        w_win = IW'(v_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ptr <= '0;
    else if (w_fire) r_ptr <= (w_win == IW'(NREQ - 1)) ? '0 : w_win + 1'b1;
  end
`endif

  assign w_fire      = (r_state == S_RUN) && w_any;
  assign req_ready_o = (w_fire && rst_n) ? f_onehot(w_win) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RUN;
      r_settle   <= 1'b0;
      r_again    <= 1'b0;
      r_busy     <= 1'b0;
      r_tag_vld  <= '0;
      r_rsp_vld  <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_base     <= '0;
      r_depth    <= BPP16;
      r_width    <= '0;
      r_rsp_addr <= '0;
      r_rsp_mb   <= '0;
      r_rsp_me   <= '0;
      r_rsp_ce   <= '0;
    end else begin
      r_tag_vld <= {r_tag_vld[LAT-2:0], w_fire};
      r_rsp_vld <= r_tag_vld[LAT-1] ? f_onehot(r_tag_id[LAT-1]) : '0;
      // Masks arrive a cycle ahead of the address; the delayed copy pairs them up.
      if (r_tag_vld[LAT-1]) begin
        r_rsp_addr <= calc_address_i;
        r_rsp_mb   <= r_mb_d;
        r_rsp_me   <= r_me_d;
        r_rsp_ce   <= r_ce_d;
      end
      if (w_fire) begin
        r_x <= req_x_i[16*w_win +: 16];
        r_y <= req_y_i[16*w_win +: 16];
      end
      if (cfg_upd_i) begin
        r_busy  <= 1'b1;
        r_again <= 1'b1;
      end
      case (r_state)
        S_RUN: if (cfg_upd_i) r_state <= S_DRAIN;
        S_DRAIN: if ((r_tag_vld == '0) && (r_rsp_vld == '0)) r_state <= S_APPLY;
        S_APPLY: begin
          r_base   <= r_pend_base;
          r_depth  <= r_pend_depth;
          r_width  <= r_pend_width;
          r_again  <= cfg_upd_i;
          r_settle <= 1'b0;
          r_state  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (!r_settle) begin
            r_settle <= 1'b1;
          end else if (r_again || cfg_upd_i) begin
            // A pulse landed after the copy; run the sequence again for it.
            r_state <= S_DRAIN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_RUN;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    r_tag_id[0] <= w_win;
    for (int i = 1; i < LAT; i++) r_tag_id[i] <= r_tag_id[i-1];
    r_mb_d <= calc_mb_i;
    r_me_d <= calc_me_i;
    r_ce_d <= calc_ce_i;
    if (cfg_upd_i) begin
      r_pend_base  <= cfg_base_i;
      r_pend_depth <= cfg_depth_i;
      r_pend_width <= cfg_width_i;
    end
  end

  assign cfg_busy_o    = r_busy;
  assign calc_x_o      = r_x;
  assign calc_y_o      = r_y;
  assign calc_base_o   = r_base;
  assign calc_depth_o  = r_depth;
  assign calc_width_o  = r_width;
  assign rsp_valid_o   = r_rsp_vld;
  assign rsp_address_o = r_rsp_addr;
  assign rsp_mb_o      = r_rsp_mb;
  assign rsp_me_o      = r_rsp_me;
  assign rsp_ce_o      = r_rsp_ce;
  assign idle_o        = (r_state == S_RUN) && (r_tag_vld == '0) && (r_rsp_vld == '0);

endmodule

// File: tb/tb_gfx_addr_arbiter.sv
// Directed bench for gfx_addr_arbiter with a behavioural address calculator
// (address = base + (y*width + x)*bytes; masks from the pixel bit offset in a 128-bit strip).
module tb_gfx_addr_arbiter;

  logic        clk, rst_n;
  logic [3:0]  req_valid, req_ready;
  logic [63:0] req_x, req_y;
  logic [31:0] cfg_base;
  logic [1:0]  cfg_depth;
  logic [15:0] cfg_width;
  logic        cfg_upd, cfg_busy;
  logic [15:0] calc_x, calc_y, calc_width;
  logic [31:0] calc_base, calc_address;
  logic [1:0]  calc_depth;
  logic [6:0]  calc_mb, calc_me, calc_ce;
  logic [3:0]  rsp_valid;
  logic [31:0] rsp_address;
  logic [6:0]  rsp_mb, rsp_me, rsp_ce;
  logic        idle;
  int          n_vec, n_err;

  gfx_addr_arbiter #(.NREQ(4), .LAT(3), .BN(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_x_i(req_x), .req_y_i(req_y),
    .cfg_base_i(cfg_base), .cfg_depth_i(cfg_depth), .cfg_width_i(cfg_width),
    .cfg_upd_i(cfg_upd), .cfg_busy_o(cfg_busy),
    .calc_x_o(calc_x), .calc_y_o(calc_y),
    .calc_base_o(calc_base), .calc_depth_o(calc_depth), .calc_width_o(calc_width),
    .calc_address_i(calc_address),
    .calc_mb_i(calc_mb), .calc_me_i(calc_me), .calc_ce_i(calc_ce),
    .rsp_valid_o(rsp_valid), .rsp_address_o(rsp_address),
    .rsp_mb_o(rsp_mb), .rsp_me_o(rsp_me), .rsp_ce_o(rsp_ce),
    .idle_o(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Calculator model: masks one cycle after the coordinates, address two cycles after.
  logic [31:0] m_bpp, m_off, m_bit, m_addr1, m_addr2;
  logic [6:0]  m_mb, m_me, m_ce;
  always @(posedge clk) begin
    m_bpp = 32'(calc_depth) + 32'd1;
    m_off = 32'(calc_y) * 32'(calc_width) + 32'(calc_x);
    m_bit = m_off * m_bpp * 32'd8;
    m_addr1 <= calc_base + m_off * m_bpp;
    m_addr2 <= m_addr1;
    m_mb    <= m_bit[6:0];
    m_me    <= 7'(m_bit + m_bpp * 32'd8 - 32'd1);
    m_ce    <= m_off[6:0];
  end
  assign calc_address = m_addr2;
  assign calc_mb      = m_mb;
  assign calc_me      = m_me;
  assign calc_ce      = m_ce;

  task automatic test_reset;
    rst_n = 1'b0; req_valid = '0; req_x = '0; req_y = '0;
    cfg_base = '0; cfg_depth = '0; cfg_width = '0; cfg_upd = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (rsp_valid !== 4'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %h want 0", rsp_valid); end
    n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL reset_ready: got %h want 0", req_ready); end
    n_vec++; if (cfg_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", cfg_busy); end
    n_vec++; if (calc_depth !== 2'd1) begin n_err++; $display("FAIL reset_depth: got %0d want 1", calc_depth); end
    n_vec++; if (calc_base !== 32'h0 || calc_width !== 16'h0) begin n_err++; $display("FAIL reset_cfg: got base %h width %h want 0 0", calc_base, calc_width); end
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %b want 1", idle); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin;
    int g;
    logic [3:0] e;
    for (int k = 0; k < 4; k++) begin
      req_x[16*k +: 16] = 16'(16'h0100 * (k + 1));
      req_y[16*k +: 16] = 16'(k);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req_valid = (i < 8) ? 4'hF : 4'h0;
      #1;
      if (i < 8) begin
`ifdef GFX_ADDR_ARB_PRIO_EN
        g = 0;
`else
        g = i % 4;
`endif
        e = 4'b0001 << g;
        n_vec++; if (req_ready !== e) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", i, req_ready, e); end
      end
      if (i >= 4) begin
`ifdef GFX_ADDR_ARB_PRIO_EN
        g = 0;
`else
        g = (i - 4) % 4;
`endif
        e = 4'b0001 << g;
        n_vec++; if (rsp_valid !== e) begin n_err++; $display("FAIL rr_rsp[%0d]: got %b want %b", i, rsp_valid, e); end
        n_vec++; if (rsp_address !== 32'(32'h200 * (g + 1))) begin n_err++; $display("FAIL rr_addr[%0d]: got %h want %h", i, rsp_address, 32'h200 * (g + 1)); end
      end
    end
  endtask

  task automatic test_cfg_idle;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cfg_upd = (i == 0); cfg_base = 32'h1000; cfg_depth = 2'd1; cfg_width = 16'd640;
      #1;
      if (i >= 1 && i <= 4) begin
        n_vec++; if (cfg_busy !== 1'b1) begin n_err++; $display("FAIL cfg_busy[%0d]: got %b want 1", i, cfg_busy); end
      end
      if (i == 1) begin
        n_vec++; if (idle !== 1'b0) begin n_err++; $display("FAIL cfg_idle: got %b want 0", idle); end
      end
      if (i == 2) begin
        n_vec++; if (calc_base !== 32'h0) begin n_err++; $display("FAIL cfg_base_early: got %h want 0", calc_base); end
      end
      if (i == 3) begin
        n_vec++; if (calc_base !== 32'h1000 || calc_width !== 16'd640) begin n_err++; $display("FAIL cfg_applied: got %h %0d want 1000 640", calc_base, calc_width); end
      end
      if (i == 5) begin
        n_vec++; if (cfg_busy !== 1'b0) begin n_err++; $display("FAIL cfg_busy_clear: got %b want 0", cfg_busy); end
      end
    end
  endtask

  task automatic test_single;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_valid = (i == 0) ? 4'b0001 : 4'b0000;
      req_x[15:0] = 16'h0010; req_y[15:0] = 16'h0002;
      #1;
      if (i == 0) begin
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready: got %b want 0001", req_ready); end
      end else begin
        n_vec++; if (rsp_valid !== ((i == 4) ? 4'b0001 : 4'b0000)) begin n_err++; $display("FAIL single_rsp[%0d]: got %b", i, rsp_valid); end
      end
      if (i == 4) begin
        n_vec++; if (rsp_address !== 32'h1A20) begin n_err++; $display("FAIL single_addr: got %h want 1a20", rsp_address); end
        n_vec++; if (rsp_mb !== 7'h00 || rsp_me !== 7'h0F || rsp_ce !== 7'h10) begin n_err++; $display("FAIL single_mask: got %h %h %h want 00 0f 10", rsp_mb, rsp_me, rsp_ce); end
      end
    end
  endtask

  task automatic test_mask_align;
    logic [15:0] xs [4];
    logic [31:0] ea [4];
    logic [6:0]  emb [4];
    logic [6:0]  eme [4];
    xs  = '{16'd0, 16'd8, 16'd3, 16'd5};
    ea  = '{32'h1000, 32'h1010, 32'h1006, 32'h100A};
    emb = '{7'h00, 7'h00, 7'h30, 7'h50};
    eme = '{7'h0F, 7'h0F, 7'h3F, 7'h5F};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      req_valid = (i < 4) ? 4'b0001 : 4'b0000;
      req_x[15:0] = (i < 4) ? xs[i] : 16'h0;
      req_y[15:0] = 16'h0;
      #1;
      if (i >= 4 && i < 8) begin
        n_vec++; if (rsp_valid !== 4'b0001 || rsp_address !== ea[i-4]) begin n_err++; $display("FAIL mask_addr[%0d]: got %b %h want 0001 %h", i - 4, rsp_valid, rsp_address, ea[i-4]); end
        n_vec++; if (rsp_mb !== emb[i-4] || rsp_me !== eme[i-4] || rsp_ce !== 7'(xs[i-4])) begin n_err++; $display("FAIL mask_fields[%0d]: got %h %h %h want %h %h %h", i - 4, rsp_mb, rsp_me, rsp_ce, emb[i-4], eme[i-4], 7'(xs[i-4])); end
      end
    end
  endtask

  task automatic test_update_traffic;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      req_x[15:0] = 16'(i + 1); req_y[15:0] = 16'h0;
      req_x[31:16] = 16'd2; req_y[31:16] = 16'd1;
      req_valid = (i < 3) ? 4'b0001 : ((i <= 11) ? 4'b0010 : 4'b0000);
      cfg_upd = (i == 2); cfg_base = 32'h1000; cfg_depth = 2'd3; cfg_width = 16'd800;
      #1;
      if (i == 2) begin
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL upd_same_cycle_grant: got %b want 0001", req_ready); end
      end
      if (i >= 3 && i <= 10) begin
        n_vec++; if (req_ready !== 4'b0000 || cfg_busy !== 1'b1) begin n_err++; $display("FAIL upd_stall[%0d]: got ready %b busy %b want 0000 1", i, req_ready, cfg_busy); end
      end
      if (i >= 4 && i <= 6) begin
        n_vec++; if (rsp_valid !== 4'b0001 || rsp_address !== 32'(32'h1000 + 2 * (i - 3))) begin n_err++; $display("FAIL upd_old_cfg[%0d]: got %b %h want 0001 %h", i, rsp_valid, rsp_address, 32'h1000 + 2 * (i - 3)); end
      end
      if (i == 8) begin
        n_vec++; if (calc_depth !== 2'd1) begin n_err++; $display("FAIL upd_depth_early: got %0d want 1", calc_depth); end
      end
      if (i == 9) begin
        n_vec++; if (calc_depth !== 2'd3 || calc_width !== 16'd800) begin n_err++; $display("FAIL upd_applied: got %0d %0d want 3 800", calc_depth, calc_width); end
      end
      if (i == 11) begin
        n_vec++; if (cfg_busy !== 1'b0 || req_ready !== 4'b0010) begin n_err++; $display("FAIL upd_resume: got busy %b ready %b want 0 0010", cfg_busy, req_ready); end
      end
      if (i == 15) begin
        n_vec++; if (rsp_valid !== 4'b0010 || rsp_address !== 32'h1C88) begin n_err++; $display("FAIL upd_new_cfg: got %b %h want 0010 1c88", rsp_valid, rsp_address); end
        n_vec++; if (rsp_mb !== 7'h40 || rsp_me !== 7'h5F || rsp_ce !== 7'h22) begin n_err++; $display("FAIL upd_new_mask: got %h %h %h want 40 5f 22", rsp_mb, rsp_me, rsp_ce); end
      end
    end
  endtask

  task automatic test_double_update;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cfg_upd = (i <= 1); cfg_base = 32'h1000; cfg_depth = 2'd3;
      cfg_width = (i == 0) ? 16'd900 : 16'd1024;
      req_x[47:32] = 16'd1; req_y[47:32] = 16'd1;
      req_valid = (i >= 1 && i <= 5) ? 4'b0100 : 4'b0000;
      #1;
      if (i >= 1 && i <= 4) begin
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL dbl_stall[%0d]: got %b want 0000", i, req_ready); end
      end
      if (i == 2) begin
        n_vec++; if (calc_width !== 16'd800) begin n_err++; $display("FAIL dbl_width_early: got %0d want 800", calc_width); end
      end
      if (i == 3) begin
        n_vec++; if (calc_width !== 16'd1024) begin n_err++; $display("FAIL dbl_width: got %0d want 1024", calc_width); end
      end
      if (i == 5) begin
        n_vec++; if (cfg_busy !== 1'b0 || req_ready !== 4'b0100) begin n_err++; $display("FAIL dbl_single_seq: got busy %b ready %b want 0 0100", cfg_busy, req_ready); end
      end
      if (i == 9) begin
        n_vec++; if (rsp_valid !== 4'b0100 || rsp_address !== 32'h2004) begin n_err++; $display("FAIL dbl_rsp: got %b %h want 0100 2004", rsp_valid, rsp_address); end
        n_vec++; if (rsp_mb !== 7'h20 || rsp_me !== 7'h3F || rsp_ce !== 7'h01) begin n_err++; $display("FAIL dbl_mask: got %h %h %h want 20 3f 01", rsp_mb, rsp_me, rsp_ce); end
      end
    end
  endtask

  task automatic test_reset_midflight;
    cfg_upd = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_x[15:0] = 16'd4; req_y[15:0] = 16'd0;
      req_valid = (i <= 2) ? 4'b0001 : 4'b0000;
      if (i == 2) rst_n = 1'b0;
      if (i == 4) rst_n = 1'b1;
      #1;
      if (i == 2) begin
        n_vec++; if (rsp_valid !== 4'b0 || req_ready !== 4'b0) begin n_err++; $display("FAIL rst_ctrl: got rsp %b ready %b want 0 0", rsp_valid, req_ready); end
        n_vec++; if (calc_x !== 16'h0 || calc_depth !== 2'd1 || calc_base !== 32'h0 || calc_width !== 16'h0) begin n_err++; $display("FAIL rst_calc: got x %h depth %0d base %h width %0d", calc_x, calc_depth, calc_base, calc_width); end
        n_vec++; if (rsp_address !== 32'h0 || rsp_mb !== 7'h0 || idle !== 1'b1 || cfg_busy !== 1'b0) begin n_err++; $display("FAIL rst_data: got addr %h mb %h idle %b busy %b", rsp_address, rsp_mb, idle, cfg_busy); end
      end
      if (i >= 3) begin
        n_vec++; if (rsp_valid !== 4'b0) begin n_err++; $display("FAIL rst_no_rsp[%0d]: got %b want 0000", i, rsp_valid); end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_round_robin();
    test_cfg_idle();
    test_single();
    test_mask_align();
    test_update_traffic();
    test_double_update();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
